// File: rtl/vm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vm_pkg
//  Description : Shared types, constants and helpers for the Vector Machine
//                shift burst scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package vm_pkg;

    localparam int WORD_SIZE_DEF = 24;
    localparam int EXP_W         = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } sched_state_t;

    // Width of an index into n items; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bit position of the (single) set bit in a one-hot vector.
    function automatic int oh2idx(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage : vm_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter. One-hot grant to the first requester
//                after the last granted one, wrapping modulo NUM_REQ.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import vm_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last_grant,
    output logic [NUM_REQ-1:0] o_gnt
);

    int   w_idx;
    logic w_found;

    // Scan from last_grant+1 around the ring; first active request wins.
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_idx = int'(i_last_grant) + off;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/shifter.sv
`default_nettype none
// ============================================================================
//  Module      : shifter
//  Description : Combinational logical left shift, truncated to WORD_SIZE.
//                Any shift amount >= WORD_SIZE yields zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module shifter
    import vm_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF
) (
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic [EXP_W-1:0]     i_exp,
    output logic [WORD_SIZE-1:0] o_data
);

    localparam logic [EXP_W-1:0] c_max_sh = EXP_W'(WORD_SIZE);

    // Explicit zero for oversized shifts keeps the intent visible.
    assign o_data = (i_exp >= c_max_sh) ? '0 : (i_data << i_exp);

endmodule : shifter
`default_nettype wire

// File: rtl/shift_burst_sched.sv
`default_nettype none
// ============================================================================
//  Module      : shift_burst_sched
//  Description : Shares one shifter among NUM_REQ vector lanes. A lane is
//                granted round-robin for a whole burst; its elements stream
//                through the shifter into a registered valid/ready result.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_burst_sched
    import vm_pkg::*;
#(
    parameter  int WORD_SIZE = WORD_SIZE_DEF,
    parameter  int NUM_REQ   = 4,
    parameter  int MAX_BURST = 16,
    localparam int ID_W      = id_w(NUM_REQ),
    localparam int IDX_W     = id_w(MAX_BURST)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [NUM_REQ*WORD_SIZE-1:0] req_data,
    input  logic [NUM_REQ*EXP_W-1:0]     req_exp,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [WORD_SIZE-1:0]         res_data,
    output logic [ID_W-1:0]              res_id,
    output logic [IDX_W-1:0]             res_idx,
    output logic                         res_last,
    output logic                         busy
);

    sched_state_t         r_state;
    sched_state_t         w_state_nxt;
    logic [ID_W-1:0]      r_owner;
    logic [ID_W-1:0]      r_last_grant;
    logic [IDX_W-1:0]     r_cnt;
    logic [NUM_REQ-1:0]   w_gnt;
    logic [ID_W-1:0]      w_gnt_id;
    logic [NUM_REQ-1:0]   w_req_ready;

    logic [WORD_SIZE-1:0] w_own_data;
    logic [EXP_W-1:0]     w_own_exp;
    logic [WORD_SIZE-1:0] w_shifted;
    logic                 w_own_valid;
    logic                 w_own_last;
    logic                 w_out_free;
    logic                 w_accept;
    logic                 w_end;

    logic                 r_res_valid;
    logic [WORD_SIZE-1:0] r_res_data;
    logic [ID_W-1:0]      r_res_id;
    logic [IDX_W-1:0]     r_res_idx;
    logic                 r_res_last;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_gnt        (w_gnt)
    );

    assign w_gnt_id = ID_W'(oh2idx(32'(w_gnt)));

    // Owner mux feeding the single shared shifter.
    assign w_own_data  = req_data[r_owner*WORD_SIZE +: WORD_SIZE];
    assign w_own_exp   = req_exp[r_owner*EXP_W +: EXP_W];
    assign w_own_valid = req_valid[r_owner];
    assign w_own_last  = req_last[r_owner];

    shifter #(
        .WORD_SIZE (WORD_SIZE)
    ) u_shift (
        .i_data (w_own_data),
        .i_exp  (w_own_exp),
        .o_data (w_shifted)
    );

    // The result register can take a new element if empty or draining now.
    assign w_out_free = !r_res_valid || res_ready;
    assign w_accept   = (r_state == BURST) && w_own_valid && w_out_free;
    assign w_end      = w_own_last || (r_cnt == IDX_W'(MAX_BURST - 1));

    // Next-state and ready decode; only the owner ever sees ready.
    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = '0;
        case (r_state)
            IDLE: begin
                if (|req_valid) w_state_nxt = BURST;
            end
            BURST: begin
                w_req_ready[r_owner] = w_out_free;
                if (w_accept && w_end) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Grant ownership, burst element counter and round-robin pointer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_owner      <= '0;
            r_cnt        <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
        end else if (r_state == IDLE && (|req_valid)) begin
            r_owner <= w_gnt_id;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_end) r_last_grant <= r_owner;
        end
    end

    // Result register: loads on accept, holds while stalled, empties on drain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_id    <= '0;
            r_res_idx   <= '0;
            r_res_last  <= 1'b0;
        end else if (w_accept) begin
            r_res_valid <= 1'b1;
            r_res_data  <= w_shifted;
            r_res_id    <= r_owner;
            r_res_idx   <= r_cnt;
            r_res_last  <= w_end;
        end else if (res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign req_ready = w_req_ready;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;
    assign res_idx   = r_res_idx;
    assign res_last  = r_res_last;
    assign busy      = (r_state == BURST) || r_res_valid;

endmodule : shift_burst_sched
`default_nettype wire

// File: tb/tb_shift_burst_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_burst_sched
//  Description : Self-checking bench for shift_burst_sched. Lane streams are
//                queued per requester; a transaction-level model predicts the
//                ordered result stream, which is scoreboarded at each drain.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_burst_sched;

    localparam int W  = 24;
    localparam int N  = 4;
    localparam int MB = 16;

    typedef struct {
        logic [W-1:0] d;
        logic [7:0]   e;
        bit           last;
    } elem_t;

    typedef struct {
        logic [W-1:0] d;
        int           id;
        int           idx;
        bit           last;
    } res_t;

    logic           clk = 1'b0;
    logic           rstn;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N*W-1:0] req_data;
    logic [N*8-1:0] req_exp;
    logic [N-1:0]   req_ready;
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   res_data;
    logic [1:0]     res_id;
    logic [3:0]     res_idx;
    logic           res_last;
    logic           busy;

    elem_t lane_q[N][$];
    res_t  exp_q[$];
    int    lg_m;
    int    total = 0;
    int    bad   = 0;

    shift_burst_sched #(
        .WORD_SIZE (W),
        .NUM_REQ   (N),
        .MAX_BURST (MB)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_exp   (req_exp),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_idx   (res_idx),
        .res_last  (res_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference shift computed in a wider word, then truncated.
    function automatic logic [W-1:0] model_shift(input logic [W-1:0] d, input logic [7:0] e);
        logic [2*W-1:0] wide;
        wide = {{W{1'b0}}, d};
        if (e >= 8'(W)) return '0;
        wide = wide << e;
        return wide[W-1:0];
    endfunction

    // Predict the full result stream from the queued lane contents.
    task automatic build_expected();
        elem_t cq[N][$];
        elem_t el;
        int    owner;
        int    cnt;
        bit    fin;
        for (int i = 0; i < N; i++) cq[i] = lane_q[i];
        forever begin
            owner = -1;
            for (int k = 1; k <= N; k++) begin
                if (owner < 0 && cq[(lg_m + k) % N].size() > 0) owner = (lg_m + k) % N;
            end
            if (owner < 0) break;
            cnt = 0;
            fin = 1'b0;
            while (!fin && cq[owner].size() > 0) begin
                el  = cq[owner].pop_front();
                fin = el.last || (cnt == MB - 1);
                exp_q.push_back('{model_shift(el.d, el.e), owner, cnt, fin});
                cnt++;
            end
            lg_m = owner;
        end
    endtask

    task automatic push_burst(input int lane, input int len);
        elem_t el;
        int    r;
        for (int k = 0; k < len; k++) begin
            r    = $urandom_range(0, 9);
            el.d = W'($urandom());
            el.e = (r == 0) ? 8'd255 : (r == 1) ? 8'd24 : 8'($urandom_range(0, 23));
            el.last = (k == len - 1);
            lane_q[lane].push_back(el);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) lane_q[i].delete();
        exp_q.delete();
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        req_exp   = '0;
        res_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        idle_inputs();
        @(negedge clk);
        rstn = 1'b1;
        lg_m = N - 1;
        clear_all();
    endtask

    // Drive lanes from their queues, scoreboard every result drain.
    task automatic run_phase(input int max_cyc, input bit rr_rand, input bit gaps,
                             input int stall_at, input int abort_at,
                             output int first_hs, output int last_hs);
        res_t r;
        first_hs = -1;
        last_hs  = -1;
        for (int cyc = 0; ; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (lane_q[i].size() > 0) begin
                    req_valid[i]       = !(gaps && $urandom_range(0, 3) == 0);
                    req_last[i]        = lane_q[i][0].last;
                    req_data[i*W +: W] = lane_q[i][0].d;
                    req_exp[i*8 +: 8]  = lane_q[i][0].e;
                end else begin
                    req_valid[i]       = 1'b0;
                    req_last[i]        = 1'b0;
                    req_data[i*W +: W] = '0;
                    req_exp[i*8 +: 8]  = '0;
                end
            end
            if (cyc >= stall_at && cyc < stall_at + 5) res_ready = 1'b0;
            else res_ready = rr_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            chk("rdy_onehot", 32'($countones(req_ready) <= 1), 1);
            if (res_valid && !res_ready) chk("stall_rdy", 32'(req_ready), 0);
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_res", 0, 1);
                end else begin
                    r = exp_q.pop_front();
                    chk("res_data", 32'(res_data), 32'(r.d));
                    chk("res_id",   32'(res_id),   r.id);
                    chk("res_idx",  32'(res_idx),  r.idx);
                    chk("res_last", 32'(res_last), 32'(r.last));
                    if (first_hs < 0) first_hs = cyc;
                    last_hs = cyc;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) void'(lane_q[i].pop_front());
            end
            if (abort_at >= 0 && cyc == abort_at) return;
            if (exp_q.size() == 0) break;
            if (cyc >= max_cyc) begin
                chk("timeout_left", exp_q.size(), 0);
                break;
            end
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        #1;
        chk("drain_busy",  32'(busy), 0);
        chk("drain_valid", 32'(res_valid), 0);
        chk("lanes_empty", lane_q[0].size() + lane_q[1].size() + lane_q[2].size() + lane_q[3].size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int    fh;
        int    lh;
        elem_t el;

        rstn = 1'b0;
        idle_inputs();
        lg_m = N - 1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_data",  32'(res_data),  0);
        chk("rst_id",    32'(res_id),    0);
        chk("rst_idx",   32'(res_idx),   0);
        chk("rst_last",  32'(res_last),  0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_busy",  32'(busy),      0);

        // Single element from lane 0: arbitration cycle, accept, result.
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        req_valid      = 4'b0001;
        req_last       = 4'b0001;
        req_data[23:0] = 24'h000003;
        req_exp[7:0]   = 8'd4;
        #1;
        chk("t1_arb_ready", 32'(req_ready), 0);
        @(negedge clk);
        #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        chk("t1_noval", 32'(res_valid), 0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("t1_valid", 32'(res_valid), 1);
        chk("t1_data",  32'(res_data),  32'h30);
        chk("t1_id",    32'(res_id),    0);
        chk("t1_idx",   32'(res_idx),   0);
        chk("t1_last",  32'(res_last),  1);
        chk("t1_busy",  32'(busy),      1);
        @(negedge clk);
        #1;
        chk("t1_drained", 32'(res_valid), 0);

        // All four lanes, two 2-element bursts each, full throughput.
        do_reset();
        for (int rnd = 0; rnd < 2; rnd++)
            for (int i = 0; i < N; i++) push_burst(i, 2);
        build_expected();
        run_phase(200, 1'b0, 1'b0, 1000, -1, fh, lh);
        chk("t2_span", lh - fh, 22);

        // Shift boundaries on a single lane with valid gaps.
        el = '{24'hFFFFFF, 8'd24, 1'b0};  lane_q[1].push_back(el);
        el = '{24'hFFFFFF, 8'd255, 1'b0}; lane_q[1].push_back(el);
        el = '{24'h000001, 8'd23, 1'b1};  lane_q[1].push_back(el);
        push_burst(1, 5);
        push_burst(1, 3);
        build_expected();
        run_phase(400, 1'b1, 1'b1, 1000, -1, fh, lh);

        // Five-cycle forced stall in the middle of a burst.
        push_burst(0, 6);
        push_burst(3, 6);
        build_expected();
        run_phase(400, 1'b0, 1'b0, 4, -1, fh, lh);

        // Lane 2 overruns MAX_BURST; others get in before it is re-granted.
        do_reset();
        push_burst(2, 20);
        push_burst(3, 2);
        push_burst(0, 2);
        build_expected();
        run_phase(400, 1'b1, 1'b0, 1000, -1, fh, lh);

        // Random multi-lane traffic with random backpressure.
        for (int rnd = 0; rnd < 4; rnd++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) != 0) push_burst(i, $urandom_range(1, 18));
            end
            build_expected();
            run_phase(2000, 1'b1, 1'b0, 1000, -1, fh, lh);
        end

        // Asynchronous reset while a burst is in flight.
        push_burst(0, 8);
        push_burst(1, 8);
        build_expected();
        run_phase(400, 1'b0, 1'b0, 1000, 6, fh, lh);
        chk("t6_pre_valid", 32'(res_valid), 1);
        chk("t6_pre_busy",  32'(busy), 1);
        #1 rstn = 1'b0;
        #1;
        chk("t6_valid", 32'(res_valid), 0);
        chk("t6_data",  32'(res_data),  0);
        chk("t6_id",    32'(res_id),    0);
        chk("t6_idx",   32'(res_idx),   0);
        chk("t6_last",  32'(res_last),  0);
        chk("t6_ready", 32'(req_ready), 0);
        chk("t6_busy",  32'(busy),      0);
        idle_inputs();
        clear_all();
        lg_m = N - 1;
        @(negedge clk);
        rstn = 1'b1;
        push_burst(1, 3);
        push_burst(2, 2);
        push_burst(0, 4);
        build_expected();
        run_phase(400, 1'b1, 1'b0, 1000, -1, fh, lh);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_shift_burst_sched
`default_nettype wire
